// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event scheduler: event layout,
// repeat FSM encoding and default typematic timing.
package kbd_pkg;

    localparam int EV_W          = 19;
    localparam int EV_REPEAT_BIT = 18;

    localparam int DEF_DEPTH         = 8;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 1666667;
    localparam int DEF_CNT_W         = 25;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic logic [EV_W-1:0] make_event(
        input logic       rep,
        input logic       e0,
        input logic       is_ascii,
        input logic [7:0] ascii,
        input logic [7:0] code
    );
        return {rep, e0, is_ascii, ascii, code};
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO with registered occupancy; head entry read combinationally.
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot for a same-cycle push when full
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_scheduler.sv
// Keyboard event queue with typematic auto-repeat.
// Define KBD_REPEAT_EN to compile in the repeat FSM and timer.
module kbd_event_scheduler
    import kbd_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   key_valid,
    input  logic [7:0]             key_code,
    input  logic                   key_e0,
    input  logic [7:0]             key_ascii,
    input  logic                   key_is_ascii,
    input  logic                   key_down,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [EV_W-1:0]        ev_data,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic [EV_W-1:0] din;
    logic [EV_W-1:0] real_ev;

    assign real_ev  = make_event(1'b0, key_e0, key_is_ascii,
                                 key_ascii, key_code);
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;

`ifdef KBD_REPEAT_EN
    logic [1:0]        state;
    logic [CNT_W-1:0]  timer;
    logic [EV_W-2:0]   cand;
    logic              rep_fire;

    // Release in the expiry cycle suppresses the repeat
    assign rep_fire = (state != ST_IDLE) & key_down & (timer == '0);
    assign push     = key_valid | rep_fire;
    assign din      = key_valid ? real_ev : {1'b1, cand};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
            timer <= '0;
            cand  <= '0;
        end else if (key_valid & key_is_ascii) begin
            cand  <= real_ev[EV_REPEAT_BIT-1:0];
            timer <= CNT_W'(REPEAT_DELAY - 1);
            state <= ST_DELAY;
        end else if (key_valid) begin
            state <= ST_IDLE;
            timer <= '0;
        end else if (state != ST_IDLE) begin
            if (!key_down) begin
                state <= ST_IDLE;
                timer <= '0;
            end else if (timer == '0) begin
                timer <= CNT_W'(REPEAT_PERIOD - 1);
                state <= ST_REPEAT;
            end else begin
                timer <= timer - 1'b1;
            end
        end
    end
`else
    logic unused_ok;

    assign push      = key_valid;
    assign din       = real_ev;
    assign unused_ok = key_down ^ (REPEAT_DELAY == 0)
                     ^ (REPEAT_PERIOD == 0) ^ (CNT_W == 0);
`endif

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (ev_data),
        .full  (full),
        .empty (empty),
        .count (ev_count)
    );

    // Only real key events count as lost; dropped repeats are silent
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ovf <= 1'b0;
        end else if (key_valid & full & ~pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
